// File: rtl/dpb_bridge_sequencer_if.sv
// Host <-> sequencer <-> bridge signal bundle for dpb_bridge_sequencer.
// The master side is the host/bridge environment; the slave side is the sequencer.
interface dpb_bridge_sequencer_if #(
  parameter int TIMEOUT_W = 24
) ();
  logic                 i_cmd_stb;
  logic [1:0]           i_cmd;
  logic [15:0]          i_blocks;
  logic [TIMEOUT_W-1:0] i_timeout;
  logic                 i_abort_stb;
  logic                 i_bridge_idle;
  logic [31:0]          i_num_reads;
  logic                 o_mem_2_ppfifo_stb;
  logic                 o_ppfifo_2_mem_en;
  logic                 o_cancel_write_stb;
  logic                 o_busy;
  logic                 o_done_stb;
  logic                 o_error;
  logic [15:0]          o_blocks_done;

  // Handshake: i_cmd_stb is a single-cycle request that is accepted only
  // while o_busy==0; completion is a single-cycle o_done_stb, with o_error
  // and o_blocks_done holding the outcome until the next accepted command.
  modport master (
    output i_cmd_stb, i_cmd, i_blocks, i_timeout, i_abort_stb,
    output i_bridge_idle, i_num_reads,
    input  o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb,
    input  o_busy, o_done_stb, o_error, o_blocks_done
  );

  modport slave (
    input  i_cmd_stb, i_cmd, i_blocks, i_timeout, i_abort_stb,
    input  i_bridge_idle, i_num_reads,
    output o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb,
    output o_busy, o_done_stb, o_error, o_blocks_done
  );
endinterface

// File: rtl/dpb_bridge_sequencer.sv
// Command sequencer for the BRAM <-> ping-pong-FIFO bridge: runs one write/read/cancel
// command at a time, with a per-block watchdog, abort, and done/error reporting.
module dpb_bridge_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  dpb_bridge_sequencer_if.slave   bus,
  output logic [3:0]              o_dbg_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_STB    = 4'd1,
    S_WR_SETTLE = 4'd2,
    S_WR_WAIT   = 4'd3,
    S_RD_ARM    = 4'd4,
    S_RD_WAIT   = 4'd5,
    S_RD_DRAIN  = 4'd6,
    S_CANCEL    = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic                 idle_meta_q, idle_s_q;
  logic [SW-1:0]        settle_q, settle_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [15:0]          target_q, target_d;
  logic [31:0]          base_q, base_d;
  logic [15:0]          blocks_done_q, blocks_done_d;
  logic                 error_q, error_d;
  logic                 en_q, en_d;

  logic [31:0]          rd_cnt;
  logic [TIMEOUT_W-1:0] wdog_inc;
  logic                 wdog_hit;
  logic                 abort_hit;
  logic [15:0]          wr_next;

  // Modular difference keeps the read progress correct across counter wrap.
  assign rd_cnt    = bus.i_num_reads - base_q;
  assign wdog_inc  = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
  assign wdog_hit  = (bus.i_timeout != '0) && (wdog_q == bus.i_timeout);
  assign wr_next   = blocks_done_q + 16'd1;
  assign abort_hit = bus.i_abort_stb &&
                     (state_q != S_IDLE) && (state_q != S_CANCEL) && (state_q != S_DONE);

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    wdog_d        = wdog_q;
    target_d      = target_q;
    base_d        = base_q;
    blocks_done_d = blocks_done_q;
    error_d       = error_q;
    en_d          = en_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_stb) begin
          error_d       = 1'b0;
          blocks_done_d = 16'd0;
          target_d      = bus.i_blocks;
          base_d        = bus.i_num_reads;
          wdog_d        = '0;
          unique case (bus.i_cmd)
            2'd1:    state_d = (bus.i_blocks == 16'd0) ? S_DONE : S_WR_STB;
            2'd2:    state_d = (bus.i_blocks == 16'd0) ? S_DONE : S_RD_ARM;
            2'd3:    state_d = S_CANCEL;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WR_STB: begin
        settle_d = '0;
        wdog_d   = '0;
        state_d  = S_WR_SETTLE;
      end
      S_WR_SETTLE: begin
        if (wdog_hit) begin
          error_d = 1'b1;
          state_d = S_CANCEL;
        end else begin
          wdog_d = wdog_inc;
          if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = S_WR_WAIT;
          else                                    settle_d = settle_q + 1'b1;
        end
      end
      S_WR_WAIT: begin
        // Completion is checked before the watchdog so a same-cycle tie succeeds.
        if (idle_s_q) begin
          blocks_done_d = wr_next;
          state_d       = (wr_next == target_q) ? S_DONE : S_WR_STB;
        end else if (wdog_hit) begin
          error_d = 1'b1;
          state_d = S_CANCEL;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_RD_ARM: begin
        en_d    = 1'b1;
        wdog_d  = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        blocks_done_d = rd_cnt[15:0];
        if (rd_cnt >= {16'd0, target_q}) begin
          en_d    = 1'b0;
          wdog_d  = '0;
          state_d = S_RD_DRAIN;
        end else if (rd_cnt[15:0] != blocks_done_q) begin
          wdog_d = '0;
        end else if (wdog_hit) begin
          error_d = 1'b1;
          en_d    = 1'b0;
          state_d = S_CANCEL;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_RD_DRAIN: begin
        if (idle_s_q) begin
          state_d = S_DONE;
        end else if (wdog_hit) begin
          error_d = 1'b1;
          state_d = S_CANCEL;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_CANCEL: begin
        en_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any progress made in the same cycle.
    if (abort_hit) begin
      error_d       = 1'b1;
      en_d          = 1'b0;
      blocks_done_d = blocks_done_q;
      state_d       = S_CANCEL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idle_meta_q   <= 1'b1;
      idle_s_q      <= 1'b1;
      settle_q      <= '0;
      wdog_q        <= '0;
      target_q      <= 16'd0;
      base_q        <= 32'd0;
      blocks_done_q <= 16'd0;
      error_q       <= 1'b0;
      en_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_meta_q   <= bus.i_bridge_idle;
      idle_s_q      <= idle_meta_q;
      settle_q      <= settle_d;
      wdog_q        <= wdog_d;
      target_q      <= target_d;
      base_q        <= base_d;
      blocks_done_q <= blocks_done_d;
      error_q       <= error_d;
      en_q          <= en_d;
    end
  end

  assign bus.o_mem_2_ppfifo_stb = (state_q == S_WR_STB);
  assign bus.o_cancel_write_stb = (state_q == S_CANCEL);
  assign bus.o_done_stb         = (state_q == S_DONE);
  assign bus.o_busy             = (state_q != S_IDLE);
  assign bus.o_ppfifo_2_mem_en  = en_q;
  assign bus.o_error            = error_q;
  assign bus.o_blocks_done      = blocks_done_q;
  assign o_dbg_state            = state_q;

endmodule

// File: tb/tb_dpb_bridge_sequencer.sv
// Directed bench for dpb_bridge_sequencer: write, read, wrap, timeout, abort,
// reset-mid-command and zero-block commands, with a simple bridge idle model.
`timescale 1ns/1ps
module tb_dpb_bridge_sequencer;

  localparam int TIMEOUT_W = 24;

  logic       clk;
  logic       rst;
  logic [3:0] dbg_state;

  dpb_bridge_sequencer_if #(.TIMEOUT_W(TIMEOUT_W)) bus ();

  dpb_bridge_sequencer #(.SETTLE_CYCLES(4), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  // bridge model: goes busy for 10 cycles after each write strobe
  int   bridge_cnt = 0;
  logic force_low  = 1'b0;
  int   n_mem = 0, n_cancel = 0, n_done = 0;

  always @(negedge clk) begin
    if (bus.o_mem_2_ppfifo_stb) bridge_cnt = 10;
    else if (bridge_cnt != 0)   bridge_cnt = bridge_cnt - 1;
    if (bus.o_mem_2_ppfifo_stb) n_mem++;
    if (bus.o_cancel_write_stb) n_cancel++;
    if (bus.o_done_stb)         n_done++;
  end

  assign bus.i_bridge_idle = (bridge_cnt == 0) && !force_low;

  // scoreboard counters
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [15:0] blocks);
    bus.i_cmd_stb = 1'b1;
    bus.i_cmd     = cmd;
    bus.i_blocks  = blocks;
    step();
    bus.i_cmd_stb = 1'b0;
  endtask

  function automatic logic sig(input int which);
    return (which == 0) ? bus.o_done_stb : bus.o_cancel_write_stb;
  endfunction

  task automatic wait_for(input string tag, input int which, input int max, output int cyc);
    cyc = 0;
    while (!sig(which) && cyc < max) begin
      step();
      cyc++;
    end
    chk(tag, {31'd0, sig(which)}, 32'd1);
  endtask

  int cyc;
  int m0, c0, d0;

  initial begin
    rst             = 1'b0;
    bus.i_cmd_stb   = 1'b0;
    bus.i_cmd       = 2'd0;
    bus.i_blocks    = 16'd0;
    bus.i_timeout   = '0;
    bus.i_abort_stb = 1'b0;
    bus.i_num_reads = 32'd0;
    step();
    step();
    chk("rst_busy",        {31'd0, bus.o_busy}, 32'd0);
    chk("rst_error",       {31'd0, bus.o_error}, 32'd0);
    chk("rst_blocks_done", {16'd0, bus.o_blocks_done}, 32'd0);
    chk("rst_en",          {31'd0, bus.o_ppfifo_2_mem_en}, 32'd0);
    chk("rst_done_stb",    {31'd0, bus.o_done_stb}, 32'd0);
    chk("rst_state",       {28'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    step();

    // WRITE_OUT 3 blocks; a CANCEL strobe while busy must be dropped
    m0 = n_mem;
    c0 = n_cancel;
    issue(2'd1, 16'd3);
    chk("wr_busy",    {31'd0, bus.o_busy}, 32'd1);
    chk("wr_mem_stb", {31'd0, bus.o_mem_2_ppfifo_stb}, 32'd1);
    step();
    issue(2'd3, 16'd7);
    wait_for("wr_done_wait", 0, 200, cyc);
    chk("wr_stb_count",   n_mem - m0, 32'd3);
    chk("wr_blocks_done", {16'd0, bus.o_blocks_done}, 32'd3);
    chk("wr_error",       {31'd0, bus.o_error}, 32'd0);
    step();
    chk("wr_busy_after",   {31'd0, bus.o_busy}, 32'd0);
    chk("wr_no_cancel",    n_cancel - c0, 32'd0);

    // READ_IN 2 blocks: num_reads 5 -> 6 -> 7
    bus.i_num_reads = 32'd5;
    issue(2'd2, 16'd2);
    step();
    step();
    chk("rd_en_high", {31'd0, bus.o_ppfifo_2_mem_en}, 32'd1);
    force_low       = 1'b1;
    bus.i_num_reads = 32'd6;
    step();
    step();
    chk("rd_blocks_1", {16'd0, bus.o_blocks_done}, 32'd1);
    chk("rd_en_still", {31'd0, bus.o_ppfifo_2_mem_en}, 32'd1);
    bus.i_num_reads = 32'd7;
    step();
    chk("rd_en_drop", {31'd0, bus.o_ppfifo_2_mem_en}, 32'd0);
    step();
    step();
    chk("rd_drain_busy", {31'd0, bus.o_busy}, 32'd1);
    force_low = 1'b0;
    wait_for("rd_done_wait", 0, 20, cyc);
    chk("rd_blocks_done", {16'd0, bus.o_blocks_done}, 32'd2);
    chk("rd_error",       {31'd0, bus.o_error}, 32'd0);
    step();

    // READ_IN 1 block across the 32-bit count wrap
    bus.i_num_reads = 32'hFFFF_FFFF;
    issue(2'd2, 16'd1);
    step();
    step();
    chk("wrap_en",     {31'd0, bus.o_ppfifo_2_mem_en}, 32'd1);
    chk("wrap_blocks0", {16'd0, bus.o_blocks_done}, 32'd0);
    bus.i_num_reads = 32'd0;
    wait_for("wrap_done_wait", 0, 20, cyc);
    chk("wrap_blocks_done", {16'd0, bus.o_blocks_done}, 32'd1);
    chk("wrap_error",       {31'd0, bus.o_error}, 32'd0);
    step();

    // WRITE_OUT 1 block, timeout 50, bridge idle stuck low
    force_low     = 1'b1;
    bus.i_timeout = 24'd50;
    issue(2'd1, 16'd1);
    wait_for("to_cancel_wait", 1, 100, cyc);
    chk("to_cancel_cycle", cyc, 32'd52);
    chk("to_error",        {31'd0, bus.o_error}, 32'd1);
    step();
    chk("to_done_stb", {31'd0, bus.o_done_stb}, 32'd1);
    step();
    chk("to_idle", {31'd0, bus.o_busy}, 32'd0);
    force_low     = 1'b0;
    bus.i_timeout = '0;
    step();

    // abort during RD_WAIT, then a NOP clears the sticky error
    c0 = n_cancel;
    bus.i_num_reads = 32'd100;
    issue(2'd2, 16'd3);
    step();
    step();
    chk("ab_en_high", {31'd0, bus.o_ppfifo_2_mem_en}, 32'd1);
    bus.i_abort_stb = 1'b1;
    step();
    bus.i_abort_stb = 1'b0;
    chk("ab_cancel_stb", {31'd0, bus.o_cancel_write_stb}, 32'd1);
    chk("ab_en_low",     {31'd0, bus.o_ppfifo_2_mem_en}, 32'd0);
    chk("ab_error",      {31'd0, bus.o_error}, 32'd1);
    step();
    chk("ab_done_stb", {31'd0, bus.o_done_stb}, 32'd1);
    step();
    chk("ab_cancel_count", n_cancel - c0, 32'd1);
    chk("ab_error_sticky", {31'd0, bus.o_error}, 32'd1);
    issue(2'd0, 16'd0);
    chk("nop_error_clr", {31'd0, bus.o_error}, 32'd0);
    chk("nop_not_busy",  {31'd0, bus.o_busy}, 32'd0);

    // reset in the middle of a WRITE_OUT
    bus.i_num_reads = 32'd0;
    issue(2'd1, 16'd2);
    step();
    step();
    d0 = n_done;
    c0 = n_cancel;
    rst = 1'b0;
    step();
    chk("mid_rst_busy",    {31'd0, bus.o_busy}, 32'd0);
    chk("mid_rst_stb",     {31'd0, bus.o_mem_2_ppfifo_stb}, 32'd0);
    chk("mid_rst_blocks",  {16'd0, bus.o_blocks_done}, 32'd0);
    chk("mid_rst_state",   {28'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_no_done",   n_done - d0, 32'd0);
    chk("mid_rst_no_cancel", n_cancel - c0, 32'd0);
    repeat (15) step();

    // zero-block command completes in two cycles
    issue(2'd1, 16'd0);
    chk("zero_done_stb", {31'd0, bus.o_done_stb}, 32'd1);
    chk("zero_busy",     {31'd0, bus.o_busy}, 32'd1);
    step();
    chk("zero_idle",      {31'd0, bus.o_busy}, 32'd0);
    chk("zero_done_low",  {31'd0, bus.o_done_stb}, 32'd0);
    chk("zero_blocks",    {16'd0, bus.o_blocks_done}, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
